// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit controller and its datapath mux.
package uart_pkg;

    localparam int unsigned SEL_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ARM    = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_e;

    localparam logic [SEL_W-1:0] SEL_IDLE   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_START  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_DATA   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_PARITY = 3'd3;
    localparam logic [SEL_W-1:0] SEL_STOP   = 3'd4;

    // Per-frame options captured when a word is accepted.
    typedef struct packed {
        logic parity_en;
        logic stop2;
    } frame_cfg_t;

endpackage

// File: rtl/uart_bit_cnt.sv
// Data-bit index counter with synchronous clear, enable and a last-bit flag.
module uart_bit_cnt #(
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = $clog2(DATA_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_last = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, DATA_W data bits, optional parity, one or two
// stop bits, paced by an external baud tick and driving the TX datapath controls.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = $clog2(DATA_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_baud_tick,
    input  logic             i_data_valid,
    output logic             o_ready,
    input  logic             i_parity_en,
    input  logic             i_stop2,
    input  logic             i_abort,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_load,
    output logic             o_shift,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_bit_idx
);

    state_e     state_q, state_d;
    frame_cfg_t cfg_q, cfg_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       done_q, done_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    uart_bit_cnt #(.DATA_W(DATA_W)) u_bit_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (cnt_clr),
        .i_en   (cnt_en),
        .o_cnt  (cnt),
        .o_last (cnt_last)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            stop_cnt_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            stop_cnt_q <= stop_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        o_sel      = SEL_IDLE;
        o_ready    = 1'b0;
        o_busy     = 1'b1;
        o_load     = 1'b0;
        o_shift    = 1'b0;
        o_bit_idx  = '0;

        case (state_q)
            ST_IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_data_valid) begin
                    cfg_d.parity_en = i_parity_en;
                    cfg_d.stop2     = i_stop2;
                    state_d         = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_load  = 1'b1;
                state_d = ST_ARM;
            end
            // Wait for a tick so the start bit spans a full bit period.
            ST_ARM: begin
                if (i_baud_tick) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                o_sel = SEL_START;
                if (i_baud_tick) begin
                    cnt_clr = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                o_sel     = SEL_DATA;
                o_bit_idx = cnt;
                if (i_baud_tick) begin
                    o_shift = 1'b1;
                    if (cnt_last) begin
                        cnt_clr = 1'b1;
                        state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                o_sel = SEL_PARITY;
                if (i_baud_tick) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                o_sel = SEL_STOP;
                if (i_baud_tick) begin
                    if (cfg_q.stop2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_clr    = 1'b1;
                stop_cnt_d = 1'b0;
            end
        endcase

        // Abort outranks both accept and tick.
        if (i_abort) begin
            state_d    = ST_IDLE;
            cfg_d      = cfg_q;
            stop_cnt_d = 1'b0;
            done_d     = 1'b0;
            cnt_clr    = 1'b1;
            cnt_en     = 1'b0;
            o_shift    = 1'b0;
        end
    end

    assign o_done = done_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Parametrised UART transmit controller that sequences one serial frame per accepted word: start bit, DATA_W data bits, optional parity bit, one or two stop bits. It is paced by an external baud-tick strobe and drives the select, load and shift controls of the TX datapath (shift register, parity generator, output mux). It replaces the fixed 8-bit controller by adding:
- an internal bit counter
- per-frame configuration
- a ready/valid handshake
- abort and done signalling

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- CNT_W, $clog2(DATA_W), derived localparam; width of the bit index.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_baud_tick  in  1  one-cycle strobe, one per bit period.
- i_data_valid  in  1  word available in the datapath holding register.
- o_ready  out  1  controller accepts a word this cycle.
- i_parity_en  in  1  frame includes a parity bit; sampled at accept.
- i_stop2  in  1  frame uses two stop bits; sampled at accept.
- i_abort  in  1  synchronous abort of the current frame.
- o_sel  out  3  datapath line select: 0 idle/high, 1 start, 2 data, 3 parity, 4 stop.
- o_load  out  1  load the shift register and parity generator.
- o_shift  out  1  advance the shift register by one bit.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse when a frame completes normally.
- o_bit_idx  out  CNT_W  index of the data bit currently on the line.

## Operation
- States: IDLE, LOAD, ARM, START, DATA, PARITY, STOP.
- Reset state: IDLE. Reset values: o_sel=0, o_busy=0, o_ready=1, o_load=0, o_shift=0, o_done=0, o_bit_idx=0, bit counter=0, stop counter=0, latched config=0.
- IDLE: o_ready=1. If i_data_valid=1 and i_abort=0, then accept the word, latch i_parity_en and i_stop2, and go to LOAD.
- LOAD: lasts exactly 1 cycle. o_load=1, o_sel=0. Always goes to ARM; i_baud_tick is ignored.
- ARM: o_sel=0. Waits for i_baud_tick, then goes to START. This aligns the start bit to a full bit period.
- START: o_sel=1. On tick, clear the bit counter and go to DATA.
- DATA: o_sel=2, o_bit_idx = bit counter. Each tick: o_shift=1 for that cycle and the bit counter increments.
  - On the tick with counter = DATA_W-1: go to PARITY if the latched parity_en=1, otherwise go to STOP.
- PARITY: o_sel=3. On tick, go to STOP.
- STOP: o_sel=4.
  - On a tick with the latched stop2=1 and stop counter=0: set the stop counter to 1 and stay in STOP.
  - On any other tick: clear the stop counter, go to IDLE, and register o_done=1.
- o_busy=1 in every state except IDLE. o_ready=1 only in IDLE.
- o_done is a registered pulse. It is high during the first IDLE cycle after a normal completion and is never asserted on abort or reset.
- i_abort=1 in any state goes to IDLE on the next edge:
  - clears both counters
  - o_done stays 0
  - abort has priority over accept and over a tick.
- Async reset mid-frame: all state and outputs go immediately to their reset values.
- i_parity_en and i_stop2 changing mid-frame have no effect.
- Unused state encodings recover to IDLE.

## Timing
- Accept edge t: LOAD in cycle t+1, ARM from t+2.
- Frame length on the line is 1 + DATA_W + P + S tick periods, where P = latched parity_en and S = 1 + latched stop2. Each line state spans exactly one tick interval.
- All state transitions after LOAD occur only on edges where i_baud_tick=1.
- o_sel, o_busy, o_ready, o_load, o_shift and o_bit_idx are combinational from the registered state, counter and tick. o_done is registered.
- Back-to-back frames need at least one IDLE cycle (o_ready=1) between STOP and the next LOAD.

## Structure
- Shared package uart_pkg holds:
  - state encoding constants (IDLE..STOP)
  - o_sel codes: SEL_IDLE=0, SEL_START=1, SEL_DATA=2, SEL_PARITY=3, SEL_STOP=4

  The datapath mux uses the same package.
- One sub-module: uart_bit_cnt, a CNT_W-bit counter with clear, enable and terminal flag at DATA_W-1.
- Next-state logic, output decode and the stop counter stay in uart_tx_ctrl.

## Test plan
- Configuration for all scenarios: DATA_W=8, tick every 16 clocks.
- Basic frame, parity off, 1 stop: valid pulse -> o_load one cycle; o_sel sequence 1, then 2 for 8 tick periods, then 4 for 1 tick period; 8 o_shift pulses; o_done once; 10 tick periods total.
- Parity on, stop2 on: o_sel goes 1, then 2×8 tick periods, then 3 for 1 tick period, then 4 for 2 tick periods; 12 tick periods total; o_bit_idx runs 0..7.
- Config change mid-frame: i_parity_en toggled during DATA -> frame still follows the config latched at accept.
- Abort during DATA at bit 3 -> IDLE next cycle, o_sel=0, o_busy=0, no o_done; next frame starts with o_bit_idx=0.
- Edge cases:
  - Async reset asserted during PARITY -> all outputs return to reset values immediately.
  - i_abort with i_data_valid in IDLE -> no LOAD.
  - Tick in the LOAD cycle -> ignored; START begins on the following tick.
- DATA_W=5 and DATA_W=9 builds: exactly 5 or 9 data-bit periods and o_shift pulses; parity and stop sequencing unchanged.
